// File: rtl/aes_inv_key_controller.sv
// aes_inv_key_controller
// Runs the AES-128 key schedule forward from the cipher key to round key 10,
// then walks it backwards and streams round keys 10..0 to the inverse-cipher
// stages through one-hot set_inv_key strobes. A single SubWord unit is shared
// by both directions: it sees w3 going forward and w3^w2 going backward.
// Optional feature macro: AES_INV_KEY_PRELOAD_EN (adds key_is_final so an
// accepted key can be taken directly as round key 10).
module aes_inv_key_controller #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid,
   input  logic [127:0]          key_in,
`ifdef AES_INV_KEY_PRELOAD_EN
   input  logic                  key_is_final,
`endif
   output logic                  key_ready,
   output logic [127:0]          key_out,
   output logic [NUM_ROUNDS:0]   set_inv_key,
   output logic                  busy,
   output logic                  hold_data,
   output logic                  keys_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_INV  = 2'd2
   } state_t;

   localparam logic [3:0] LP_LAST_IDX = 4'(NUM_ROUNDS);

   // Multiply by x in GF(2^8) with the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply, shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         else      p = p;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // AES S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Round constant for round index 1..10, top byte of the word.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [127:0]          r_work_key;
   logic [127:0]          w_work_key_nxt;
   logic [3:0]            r_idx;
   logic [3:0]            w_idx_nxt;
   logic [127:0]          r_key_out;
   logic [127:0]          w_key_out_nxt;
   logic [NUM_ROUNDS:0]   r_set_inv_key;
   logic [NUM_ROUNDS:0]   w_set_inv_key_nxt;
   logic                  r_keys_valid;
   logic                  w_keys_valid_nxt;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3;
   logic [31:0]  w_sub_in;
   logic [31:0]  w_sub_rot;
   logic [31:0]  w_sub_out;
   logic [31:0]  w_rcon_word;
   logic [31:0]  w_fwd0, w_fwd1, w_fwd2, w_fwd3;
   logic [127:0] w_fwd_key;
   logic [127:0] w_inv_key;
   logic         w_accept;
   logic         w_preload;

   assign w_w0 = r_work_key[127:96];
   assign w_w1 = r_work_key[95:64];
   assign w_w2 = r_work_key[63:32];
   assign w_w3 = r_work_key[31:0];

   // Shared SubWord(RotWord()) datapath; the input word depends on direction.
   assign w_sub_in    = (r_state == ST_INV) ? (w_w3 ^ w_w2) : w_w3;
   assign w_sub_rot   = {w_sub_in[23:0], w_sub_in[31:24]};
   assign w_sub_out   = {sbox(w_sub_rot[31:24]), sbox(w_sub_rot[23:16]),
                         sbox(w_sub_rot[15:8]),  sbox(w_sub_rot[7:0])};
   assign w_rcon_word = {rcon(r_idx), 24'h000000};

   assign w_fwd0    = w_w0 ^ w_sub_out ^ w_rcon_word;
   assign w_fwd1    = w_w1 ^ w_fwd0;
   assign w_fwd2    = w_w2 ^ w_fwd1;
   assign w_fwd3    = w_w3 ^ w_fwd2;
   assign w_fwd_key = {w_fwd0, w_fwd1, w_fwd2, w_fwd3};
   assign w_inv_key = {w_w0 ^ w_sub_out ^ w_rcon_word, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

   assign w_accept  = key_valid && (r_state == ST_IDLE);
`ifdef AES_INV_KEY_PRELOAD_EN
   assign w_preload = key_is_final;
`else
   assign w_preload = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and next-datapath decisions for accept, forward and inverse phases.
   always_comb begin
      w_state_nxt       = r_state;
      w_work_key_nxt    = r_work_key;
      w_idx_nxt         = r_idx;
      w_key_out_nxt     = r_key_out;
      w_set_inv_key_nxt = '0;
      w_keys_valid_nxt  = r_keys_valid;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_work_key_nxt   = key_in;
               w_keys_valid_nxt = 1'b0;
               if (w_preload) begin
                  w_idx_nxt   = LP_LAST_IDX;
                  w_state_nxt = ST_INV;
               end else begin
                  w_idx_nxt   = 4'd1;
                  w_state_nxt = ST_FWD;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FWD: begin
            w_work_key_nxt = w_fwd_key;
            if (r_idx < LP_LAST_IDX) begin
               w_idx_nxt = r_idx + 4'd1;
            end else begin
               w_state_nxt = ST_INV;
            end
         end
         ST_INV: begin
            w_key_out_nxt     = r_work_key;
            w_set_inv_key_nxt = {{NUM_ROUNDS{1'b0}}, 1'b1} << (LP_LAST_IDX - r_idx);
            if (r_idx != 4'd0) begin
               w_work_key_nxt = w_inv_key;
               w_idx_nxt      = r_idx - 4'd1;
            end else begin
               w_state_nxt      = ST_IDLE;
               w_keys_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work_key    <= 128'h0;
         r_idx         <= 4'd0;
         r_key_out     <= 128'h0;
         r_set_inv_key <= '0;
         r_keys_valid  <= 1'b0;
      end else begin
         r_work_key    <= w_work_key_nxt;
         r_idx         <= w_idx_nxt;
         r_key_out     <= w_key_out_nxt;
         r_set_inv_key <= w_set_inv_key_nxt;
         r_keys_valid  <= w_keys_valid_nxt;
      end
   end

   assign key_out     = r_key_out;
   assign set_inv_key = r_set_inv_key;
   assign keys_valid  = r_keys_valid;
   assign key_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state == ST_FWD) || (r_state == ST_INV);
   assign hold_data   = busy;

endmodule
